// File: rtl/dsp_stream_pkg.sv
// Shared widths and constants for the dsp_t1 stream controller slice.
// The operand bundle travels as one record so the signedness flags stay paired with their data.
package dsp_stream_pkg;

    localparam int unsigned A_W  = 20;
    localparam int unsigned B_W  = 18;
    localparam int unsigned Z_W  = 38;
    localparam int unsigned FB_W = 3;

    localparam logic [FB_W-1:0] FEEDBACK_MULT = 3'h0;

    typedef struct packed {
        logic [A_W-1:0] a;
        logic [B_W-1:0] b;
        logic           unsigned_a;
        logic           unsigned_b;
    } dsp_operands_t;

endpackage

// File: rtl/dsp_result_fifo.sv
// Synchronous first-word fall-through FIFO holding DSP products until the consumer takes them.
// An empty FIFO presents zero on data_o.
module dsp_result_fifo
    import dsp_stream_pkg::*;
#(
    parameter int unsigned DATA_W = Z_W,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                      clock_i,
    input  logic                      reset_i,
    input  logic                      push_i,
    input  logic [DATA_W-1:0]         data_i,
    input  logic                      pop_i,
    output logic [DATA_W-1:0]         data_o,
    output logic                      valid_o,
    output logic [$clog2(DEPTH):0]    count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              do_push;
    logic              do_pop;

    always_comb begin
        do_pop  = pop_i & (count != '0);
        do_push = push_i & ((count != CNT_W'(DEPTH)) | do_pop);
    end

    // Storage carries no reset; the output mux hides stale entries.
    always_ff @(posedge clock_i) begin
        if (do_push) begin
            mem[wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        valid_o = (count != '0);
        data_o  = valid_o ? mem[rd_ptr] : '0;
        count_o = count;
    end

endmodule

// File: rtl/dsp_mult_stream_ctrl.sv
// Feeds operand pairs into a dsp_t1 multiplier and collects its products into a result stream.
// Credits cover both in-flight operations and queued results, so the FIFO can never overflow.
module dsp_mult_stream_ctrl
    import dsp_stream_pkg::*;
#(
    parameter int unsigned DSP_LATENCY = 1,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic [A_W-1:0]   a_i,
    input  logic [B_W-1:0]   b_i,
    input  logic             unsigned_a_i,
    input  logic             unsigned_b_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic [A_W-1:0]   dsp_a_o,
    output logic [B_W-1:0]   dsp_b_o,
    output logic             dsp_unsigned_a_o,
    output logic             dsp_unsigned_b_o,
    output logic [FB_W-1:0]  dsp_feedback_o,
    input  logic [Z_W-1:0]   dsp_z_i,
    output logic [Z_W-1:0]   z_o,
    output logic             valid_o,
    input  logic             ready_i
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    dsp_operands_t      op_q;
    logic [DSP_LATENCY:0] tag_pipe;
    logic [CNT_W-1:0]   inflight;
    logic [CNT_W-1:0]   fifo_count;
    logic [CNT_W:0]     credits_used;
    logic               accept;
    logic               push;
    logic               pop;
    logic               fifo_valid;

    // ready_o depends only on registered counts, never on ready_i.
    always_comb begin
        credits_used = {1'b0, inflight} + {1'b0, fifo_count};
        ready_o      = !reset_i && (credits_used < (CNT_W + 1)'(FIFO_DEPTH));
        accept       = valid_i & ready_o;
        push         = tag_pipe[DSP_LATENCY];
        pop          = fifo_valid & ready_i;
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            op_q     <= '0;
            tag_pipe <= '0;
            inflight <= '0;
        end else begin
            if (accept) begin
                op_q <= '{a: a_i, b: b_i, unsigned_a: unsigned_a_i, unsigned_b: unsigned_b_i};
            end
            tag_pipe[0] <= accept;
            for (int unsigned i = 1; i <= DSP_LATENCY; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
            unique case ({accept, push})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
        end
    end

    always_comb begin
        dsp_a_o          = op_q.a;
        dsp_b_o          = op_q.b;
        dsp_unsigned_a_o = op_q.unsigned_a;
        dsp_unsigned_b_o = op_q.unsigned_b;
        dsp_feedback_o   = FEEDBACK_MULT;
    end

    dsp_result_fifo #(
        .DATA_W (Z_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_result_fifo (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .push_i  (push),
        .data_i  (dsp_z_i),
        .pop_i   (pop),
        .data_o  (z_o),
        .valid_o (fifo_valid),
        .count_o (fifo_count)
    );

    assign valid_o = fifo_valid;

endmodule

// File: tb/tb_dsp_mult_stream_ctrl.sv
// Bench for dsp_mult_stream_ctrl with a behavioural dsp_t1 stand-in (registered inputs, combinational product).
// A negedge monitor scores every output handshake against a queue of expected products.
module tb_dsp_mult_stream_ctrl;

    logic        clock_i = 1'b0;
    logic        reset_i;
    logic [19:0] a_i;
    logic [17:0] b_i;
    logic        unsigned_a_i;
    logic        unsigned_b_i;
    logic        valid_i;
    logic        ready_o;
    logic [19:0] dsp_a_o;
    logic [17:0] dsp_b_o;
    logic        dsp_unsigned_a_o;
    logic        dsp_unsigned_b_o;
    logic [2:0]  dsp_feedback_o;
    logic [37:0] dsp_z_i;
    logic [37:0] z_o;
    logic        valid_o;
    logic        ready_i;

    int total = 0;
    int bad   = 0;
    int pops  = 0;
    logic [37:0] exp_q [$];
    logic [37:0] mon_e;

    always #5 clock_i = ~clock_i;

    dsp_mult_stream_ctrl #(
        .DSP_LATENCY (1),
        .FIFO_DEPTH  (4)
    ) dut (
        .clock_i          (clock_i),
        .reset_i          (reset_i),
        .a_i              (a_i),
        .b_i              (b_i),
        .unsigned_a_i     (unsigned_a_i),
        .unsigned_b_i     (unsigned_b_i),
        .valid_i          (valid_i),
        .ready_o          (ready_o),
        .dsp_a_o          (dsp_a_o),
        .dsp_b_o          (dsp_b_o),
        .dsp_unsigned_a_o (dsp_unsigned_a_o),
        .dsp_unsigned_b_o (dsp_unsigned_b_o),
        .dsp_feedback_o   (dsp_feedback_o),
        .dsp_z_i          (dsp_z_i),
        .z_o              (z_o),
        .valid_o          (valid_o),
        .ready_i          (ready_i)
    );

    function automatic logic [37:0] ref_mult(input logic [19:0] a, input logic [17:0] b,
                                             input logic ua, input logic ub);
        longint sa, sb, p;
        sa = ua ? longint'(a) : longint'($signed(a));
        sb = ub ? longint'(b) : longint'($signed(b));
        p  = sa * sb;
        return p[37:0];
    endfunction

    // dsp_t1 stand-in: REGISTER_INPUTS=1, OUTPUT_SELECT=0
    logic [19:0] dsp_a_r;
    logic [17:0] dsp_b_r;
    logic        dsp_ua_r;
    logic        dsp_ub_r;
    always @(posedge clock_i) begin
        dsp_a_r  <= dsp_a_o;
        dsp_b_r  <= dsp_b_o;
        dsp_ua_r <= dsp_unsigned_a_o;
        dsp_ub_r <= dsp_unsigned_b_o;
    end
    assign dsp_z_i = ref_mult(dsp_a_r, dsp_b_r, dsp_ua_r, dsp_ub_r);

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, want);
        end
    endtask

    always @(negedge clock_i) begin
        if (valid_o && ready_i) begin
            pops++;
            if (exp_q.size() == 0) begin
                check("unexpected_result", {26'd0, z_o}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                mon_e = exp_q.pop_front();
                check("stream_z", {26'd0, z_o}, {26'd0, mon_e});
            end
        end
        if (reset_i) begin
            exp_q.delete();
        end else if (valid_i && ready_o) begin
            exp_q.push_back(ref_mult(a_i, b_i, unsigned_a_i, unsigned_b_i));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic drive_rand(input bit signed_only);
        a_i          = 20'($urandom);
        b_i          = 18'($urandom);
        unsigned_a_i = signed_only ? 1'b0 : 1'($urandom_range(0, 1));
        unsigned_b_i = signed_only ? 1'b0 : 1'($urandom_range(0, 1));
    endtask

    task automatic send_op(input logic [19:0] a, input logic [17:0] b, input logic ua, input logic ub);
        int n;
        @(posedge clock_i); #1;
        a_i = a; b_i = b; unsigned_a_i = ua; unsigned_b_i = ub; valid_i = 1'b1;
        n = 0;
        @(negedge clock_i);
        while (!ready_o && n < 50) begin
            n++;
            @(negedge clock_i);
        end
        if (!ready_o) check("accept_timeout", {63'd0, ready_o}, 64'd1);
        @(posedge clock_i); #1;
        valid_i = 1'b0;
    endtask

    task automatic single_op_check(input string name, input logic [19:0] a, input logic [17:0] b,
                                   input logic ua, input logic ub, input logic [37:0] want);
        int lat;
        logic [37:0] zgot;
        lat = 0;
        zgot = '0;
        send_op(a, b, ua, ub);
        for (int n = 1; n <= 10 && lat == 0; n++) begin
            @(posedge clock_i);
            @(negedge clock_i);
            if (valid_o) begin
                lat = n;
                zgot = z_o;
            end
        end
        check({name, "_latency"}, 64'(lat), 64'd2);
        check({name, "_z"}, {26'd0, zgot}, {26'd0, want});
        @(posedge clock_i);
        @(negedge clock_i);
        check({name, "_valid_one_cycle"}, {63'd0, valid_o}, 64'd0);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || valid_o) && n < 200) begin
            n++;
            @(negedge clock_i);
        end
        check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
        check({name, "_valid_idle"}, {63'd0, valid_o}, 64'd0);
    endtask

    task automatic stream_ops(input string name, input int count, input bit signed_only);
        @(posedge clock_i); #1;
        valid_i = 1'b1;
        drive_rand(signed_only);
        for (int i = 0; i < count; i++) begin
            @(negedge clock_i);
            check({name, "_ready"}, {63'd0, ready_o}, 64'd1);
            @(posedge clock_i); #1;
            drive_rand(signed_only);
        end
        valid_i = 1'b0;
    endtask

    typedef struct {
        string       name;
        logic [19:0] a;
        logic [17:0] b;
        logic        ua;
        logic        ub;
        logic [37:0] z;
    } vec_t;

    vec_t vecs [7];
    int   accepts;
    int   pops_before;

    initial begin
        vecs[0] = '{"s3_x_m5",     20'h00003, 18'h3FFFB, 1'b0, 1'b0, 38'h3F_FFFF_FFF1};
        vecs[1] = '{"ua_max_x2",   20'hFFFFF, 18'h00002, 1'b1, 1'b0, 38'h00_001F_FFFE};
        vecs[2] = '{"sa_m1_x2",    20'hFFFFF, 18'h00002, 1'b0, 1'b0, 38'h3F_FFFF_FFFE};
        vecs[3] = '{"ub_max_x1",   20'h00001, 18'h3FFFF, 1'b0, 1'b1, 38'h00_0003_FFFF};
        vecs[4] = '{"min_x_min",   20'h80000, 18'h20000, 1'b0, 1'b0, 38'h10_0000_0000};
        vecs[5] = '{"uu_max",      20'hFFFFF, 18'h3FFFF, 1'b1, 1'b1, 38'h3F_FFEC_0001};
        vecs[6] = '{"ua_max_x_m1", 20'hFFFFF, 18'h3FFFF, 1'b1, 1'b0, 38'h3F_FFF0_0001};

        reset_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
        a_i = '0; b_i = '0; unsigned_a_i = 1'b0; unsigned_b_i = 1'b0;

        repeat (3) @(posedge clock_i);
        @(negedge clock_i);
        check("rst_ready",    {63'd0, ready_o}, 64'd0);
        check("rst_valid",    {63'd0, valid_o}, 64'd0);
        check("rst_z",        {26'd0, z_o}, 64'd0);
        check("rst_dsp_a",    {44'd0, dsp_a_o}, 64'd0);
        check("rst_dsp_b",    {46'd0, dsp_b_o}, 64'd0);
        check("rst_dsp_flags", {62'd0, dsp_unsigned_a_o, dsp_unsigned_b_o}, 64'd0);
        check("feedback",     {61'd0, dsp_feedback_o}, 64'd0);
        @(posedge clock_i); #1;
        reset_i = 1'b0;
        @(negedge clock_i);
        check("post_rst_ready", {63'd0, ready_o}, 64'd1);

        for (int i = 0; i < 7; i++) begin
            single_op_check(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].ua, vecs[i].ub, vecs[i].z);
        end
        wait_drain("table");

        stream_ops("b2b", 64, 1'b1);
        wait_drain("b2b");

        ready_i = 1'b0;
        accepts = 0;
        @(posedge clock_i); #1;
        valid_i = 1'b1;
        drive_rand(1'b0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clock_i);
            if (ready_o) accepts++;
            @(posedge clock_i); #1;
            drive_rand(1'b0);
        end
        valid_i = 1'b0;
        @(negedge clock_i);
        check("stall_accepts", 64'(accepts), 64'd4);
        check("stall_ready",   {63'd0, ready_o}, 64'd0);
        check("stall_valid",   {63'd0, valid_o}, 64'd1);
        pops_before = pops;
        ready_i = 1'b1;
        wait_drain("stall");
        check("stall_pops", 64'(pops - pops_before), 64'd4);
        stream_ops("resume", 8, 1'b0);
        wait_drain("resume");

        ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send_op(20'(i + 1), 18'(i + 2), 1'b0, 1'b0);
        end
        @(posedge clock_i); #1;
        reset_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clock_i);
            @(negedge clock_i);
            check("midrst_valid", {63'd0, valid_o}, 64'd0);
            check("midrst_ready", {63'd0, ready_o}, 64'd0);
        end
        @(posedge clock_i); #1;
        reset_i = 1'b0;
        ready_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock_i);
            check("no_stale_valid", {63'd0, valid_o}, 64'd0);
        end
        single_op_check("after_rst", 20'd7, 18'd6, 1'b0, 1'b0, 38'd42);
        wait_drain("after_rst");

        for (int cyc = 0; cyc < 1000; cyc++) begin
            @(posedge clock_i); #1;
            drive_rand(1'b0);
            valid_i = 1'($urandom_range(0, 1));
            ready_i = 1'($urandom_range(0, 1));
        end
        @(posedge clock_i); #1;
        valid_i = 1'b0;
        ready_i = 1'b1;
        wait_drain("random");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
